// File: rtl/riscv_lsu_pkg.sv
// Types and helpers private to the load/store unit.
package riscv_lsu_pkg;
  import riscv_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Unlisted size codes fall through to the word rule.
  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = (addr_lo != 2'b00);
    if ((size == LDST_B) || (size == LDST_BU)) begin
      mis = 1'b0;
    end else if ((size == LDST_H) || (size == LDST_HU)) begin
      mis = addr_lo[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Core-wide constants shared between the pipeline and the memory subsystem.
package riscv_pkg;

  // Load/store size encoding carried on core_size_i.
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering: request-side byte enables and store replication,
// response-side load extraction with sign/zero extension.
module lsu_data_align
  import riscv_pkg::*;
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  req_size_i,
  input  logic [1:0]  req_addr_lo_i,
  input  logic [31:0] req_wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic        misaligned_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rd_i,
  output logic [31:0] ld_data_o
);

  logic        byte_mode;
  logic        half_mode;
  logic [31:0] ld_shifted;

  assign misaligned_o = lsu_misaligned(req_size_i, req_addr_lo_i);
  assign byte_mode    = (req_size_i == LDST_B) || (req_size_i == LDST_BU);
  assign half_mode    = (req_size_i == LDST_H) || (req_size_i == LDST_HU);

  always_comb begin
    be_o = 4'b1111;
    if (misaligned_o) begin
      be_o = 4'b0000;
    end else if (byte_mode) begin
      be_o = 4'b0001 << req_addr_lo_i;
    end else if (half_mode) begin
      be_o = 4'b0011 << req_addr_lo_i;
    end
  end

  // Every lane carries the datum so the enables alone select the written bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wd_o[8*gi +: 8] = byte_mode ? req_wd_i[7:0] :
                             half_mode ? req_wd_i[8*(gi%2) +: 8] :
                                         req_wd_i[8*gi +: 8];
  end

  assign ld_shifted = ld_rd_i >> {ld_addr_lo_i, 3'b000};

  always_comb begin
    unique case (ld_size_i)
      LDST_B:  ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      LDST_BU: ld_data_o = {24'b0, ld_shifted[7:0]};
      LDST_H:  ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      LDST_HU: ld_data_o = {16'b0, ld_shifted[15:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns core accesses into a registered req/ready memory
// transaction, stalling the core until completion, misalignment or timeout.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  // The counter holds the number of BUSY cycles already spent without ready.
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned CNT_W   = (TO_LAST == 0) ? 1 : $clog2(TO_LAST + 1);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q, mem_wd_d;

  logic [3:0]        be;
  logic [31:0]       wd;
  logic              misaligned;
  logic [31:0]       ld_data;
  logic              timeout_hit;

  lsu_data_align u_align (
    .req_size_i    (core_size_i),
    .req_addr_lo_i (core_addr_i[1:0]),
    .req_wd_i      (core_wd_i),
    .be_o          (be),
    .wd_o          (wd),
    .misaligned_o  (misaligned),
    .ld_size_i     (size_q),
    .ld_addr_lo_i  (addr_lo_q),
    .ld_rd_i       (mem_rd_i),
    .ld_data_o     (ld_data)
  );

  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end else begin : g_timeout
    assign timeout_hit = (cnt_q == CNT_W'(TO_LAST));
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_lo_d  = addr_lo_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;

    unique case (state_q)
      IDLE: begin
        if (core_req_i) begin
          we_d      = core_we_i;
          size_d    = core_size_i;
          addr_lo_d = core_addr_i[1:0];
          if (misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
            if (!core_we_i) rdata_d = '0;
          end else begin
            state_d    = BUSY;
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_we_d   = core_we_i;
            mem_be_d   = be;
            mem_addr_d = {core_addr_i[31:2], 2'b00};
            mem_wd_d   = wd;
          end
        end
      end
      BUSY: begin
        if (mem_ready_i || timeout_hit) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_be_d   = '0;
          mem_addr_d = '0;
          mem_wd_d   = '0;
          // Ready takes priority over a coincident timeout.
          if (mem_ready_i) begin
            if (!we_q) rdata_d = ld_data;
          end else begin
            err_d = 1'b1;
            if (!we_q) rdata_d = '0;
          end
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= '0;
      addr_lo_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= '0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_lo_q  <= addr_lo_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  // Stall releases combinationally in DONE so the core retires that cycle.
  assign core_stall_o = core_req_i & (state_q != DONE);
  assign lsu_err_o    = err_q;
  assign core_rd_o    = rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wd_o     = mem_wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: hand-computed vectors, one memory responder
// task that replies after a programmed number of BUSY cycles.
module tb_riscv_lsu;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int tests_run;
  int tests_failed;

  int          r_stall;
  int          r_busy;
  int          r_err;
  logic        r_done;
  logic        r_req_seen;
  logic        r_stable;
  logic        r_req_at_done;
  logic [31:0] r_rd;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [31:0] r_addr;
  logic        r_we;

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .lsu_err_o    (lsu_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("[TB] %s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after DONE.
  // ready_at = BUSY cycle (1-based) that receives mem_ready_i, 0 = never.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int ready_at, input logic [31:0] rword);
    int busy_n;
    busy_n        = 0;
    r_stall       = 0;
    r_err         = 0;
    r_done        = 1'b0;
    r_req_seen    = 1'b0;
    r_stable      = 1'b1;
    r_req_at_done = 1'b1;
    r_rd          = 32'hxxxx_xxxx;
    r_be          = '0;
    r_wd          = '0;
    r_addr        = '0;
    r_we          = 1'b0;
    core_req_i    = 1'b1;
    core_we_i     = we;
    core_size_i   = size;
    core_addr_i   = addr;
    core_wd_i     = wd;
    mem_rd_i      = rword;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (lsu_err_o) r_err++;
      if (!core_stall_o) begin
        r_done        = 1'b1;
        r_rd          = core_rd_o;
        r_req_at_done = mem_req_o;
        break;
      end
      r_stall++;
      if (mem_req_o) begin
        busy_n++;
        if (!r_req_seen) begin
          r_req_seen = 1'b1;
          r_be       = mem_be_o;
          r_wd       = mem_wd_o;
          r_addr     = mem_addr_o;
          r_we       = mem_we_o;
        end else if (mem_be_o !== r_be || mem_wd_o !== r_wd ||
                     mem_addr_o !== r_addr || mem_we_o !== r_we) begin
          r_stable = 1'b0;
        end
      end
      mem_ready_i = mem_req_o && (busy_n == ready_at);
    end
    core_req_i  = 1'b0;
    mem_ready_i = 1'b0;
    r_busy      = busy_n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i        = 1'b0;
    core_req_i   = 1'b0;
    core_we_i    = 1'b0;
    core_size_i  = LDST_W;
    core_addr_i  = '0;
    core_wd_i    = '0;
    mem_rd_i     = '0;
    mem_ready_i  = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",  32'(mem_req_o), 32'd0);
    check("rst_mem_we",   32'(mem_we_o), 32'd0);
    check("rst_mem_be",   32'(mem_be_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wd",   mem_wd_o, 32'd0);
    check("rst_core_rd",  core_rd_o, 32'd0);
    check("rst_err",      32'(lsu_err_o), 32'd0);
    check("rst_stall",    32'(core_stall_o), 32'd0);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    // LW 0x100, ready in first BUSY cycle
    access(1'b0, LDST_W, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
    check("lw_done",      32'(r_done), 32'd1);
    check("lw_be",        32'(r_be), 32'h0000_000F);
    check("lw_addr",      r_addr, 32'h0000_0100);
    check("lw_we",        32'(r_we), 32'd0);
    check("lw_stall",     32'(r_stall), 32'd2);
    check("lw_rd",        r_rd, 32'hDEAD_BEEF);
    check("lw_err",       32'(r_err), 32'd0);
    check("lw_req_drop",  32'(r_req_at_done), 32'd0);

    // LB / LBU at 0x103, back to back
    access(1'b0, LDST_B, 32'h0000_0103, 32'h0, 1, 32'h80FF_FF01);
    check("lb_be",        32'(r_be), 32'h0000_0008);
    check("lb_rd",        r_rd, 32'hFFFF_FF80);
    access(1'b0, LDST_BU, 32'h0000_0103, 32'h0, 1, 32'h80FF_FF01);
    check("lbu_rd",       r_rd, 32'h0000_0080);

    // SH 0x1234ABCD to 0x202, ready in third BUSY cycle
    access(1'b1, LDST_H, 32'h0000_0202, 32'h1234_ABCD, 3, 32'hFFFF_FFFF);
    check("sh_be",        32'(r_be), 32'h0000_000C);
    check("sh_wd",        r_wd, 32'hABCD_ABCD);
    check("sh_addr",      r_addr, 32'h0000_0200);
    check("sh_we",        32'(r_we), 32'd1);
    check("sh_stall",     32'(r_stall), 32'd4);
    check("sh_stable",    32'(r_stable), 32'd1);
    check("sh_rd_hold",   r_rd, 32'h0000_0080);

    // Misaligned LW 0x101
    access(1'b0, LDST_W, 32'h0000_0101, 32'h0, 1, 32'h1111_1111);
    check("mis_no_req",   32'(r_req_seen), 32'd0);
    check("mis_stall",    32'(r_stall), 32'd1);
    check("mis_err",      32'(r_err), 32'd1);
    check("mis_rd",       r_rd, 32'd0);

    // LH / LHU at 0x102
    access(1'b0, LDST_H, 32'h0000_0102, 32'h0, 2, 32'h8001_1234);
    check("lh_be",        32'(r_be), 32'h0000_000C);
    check("lh_rd",        r_rd, 32'hFFFF_8001);
    check("lh_err",       32'(r_err), 32'd0);
    check("lh_stall",     32'(r_stall), 32'd3);
    access(1'b0, LDST_HU, 32'h0000_0102, 32'h0, 1, 32'h8001_1234);
    check("lhu_rd",       r_rd, 32'h0000_8001);

    // SB 0xA5 to 0x101
    access(1'b1, LDST_B, 32'h0000_0101, 32'h1234_56A5, 1, 32'h0);
    check("sb_be",        32'(r_be), 32'h0000_0002);
    check("sb_wd",        r_wd, 32'hA5A5_A5A5);
    check("sb_addr",      r_addr, 32'h0000_0100);
    check("sb_rd_hold",   r_rd, 32'h0000_8001);

    // Size code 3 behaves as a word
    access(1'b0, 3'd3, 32'h0000_0010, 32'h0, 1, 32'h1122_3344);
    check("sz3_be",       32'(r_be), 32'h0000_000F);
    check("sz3_rd",       r_rd, 32'h1122_3344);

    // Timeout after 4 BUSY cycles
    access(1'b0, LDST_W, 32'h0000_0300, 32'h0, 0, 32'h7777_7777);
    check("to_done",      32'(r_done), 32'd1);
    check("to_busy",      32'(r_busy), 32'd4);
    check("to_stall",     32'(r_stall), 32'd5);
    check("to_err",       32'(r_err), 32'd1);
    check("to_rd",        r_rd, 32'd0);
    check("to_req_drop",  32'(r_req_at_done), 32'd0);

    // Ready coincident with timeout: ready wins
    access(1'b0, LDST_W, 32'h0000_0304, 32'h0, 4, 32'h55AA_55AA);
    check("tor_err",      32'(r_err), 32'd0);
    check("tor_rd",       r_rd, 32'h55AA_55AA);
    check("tor_stall",    32'(r_stall), 32'd5);

    // Reset asserted during BUSY
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = LDST_W;
    core_addr_i = 32'h0000_0400;
    mem_rd_i    = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("mrst_busy_req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("mrst_req",     32'(mem_req_o), 32'd0);
    check("mrst_be",      32'(mem_be_o), 32'd0);
    check("mrst_addr",    mem_addr_o, 32'd0);
    check("mrst_rd",      core_rd_o, 32'd0);
    core_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, LDST_W, 32'h0000_0404, 32'h0, 2, 32'hCAFE_F00D);
    check("prst_rd",      r_rd, 32'hCAFE_F00D);
    check("prst_stall",   32'(r_stall), 32'd3);

    // Misaligned store: no request, rd held
    access(1'b1, LDST_W, 32'h0000_0202, 32'h9999_9999, 1, 32'h0);
    check("msw_no_req",   32'(r_req_seen), 32'd0);
    check("msw_err",      32'(r_err), 32'd1);
    check("msw_rd_hold",  r_rd, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit placed between the core's data-memory port and the data memory. It sequences every core load or store into a registered request/ready handshake with the memory and holds the core stalled until the access completes. It also generates byte enables, replicates store data, and extracts and extends load data. A timeout counter aborts accesses the memory never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles before an abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- core_req_i  in  1  core requests a memory access this cycle.
- core_we_i  in  1  1 = store, 0 = load.
- core_size_i  in  3  access size: B=0, H=1, W=2, BU=4, HU=5.
- core_addr_i  in  32  byte address.
- core_wd_i  in  32  store data, right-aligned.
- core_rd_o  out  32  load result, already extended.
- core_stall_o  out  1  core must hold PC and suppress register writeback.
- lsu_err_o  out  1  one-cycle pulse on misalignment or timeout.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  memory write enable, registered.
- mem_be_o  out  4  byte enables, registered.
- mem_addr_o  out  32  word address (core_addr_i[31:2], 2'b00), registered.
- mem_wd_o  out  32  replicated store data, registered.
- mem_rd_i  in  32  memory read word; valid while mem_ready_i = 1.
- mem_ready_i  in  1  memory completion.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On core_req_i, latch we, size, addr[1:0], be, wd and go to BUSY.
  - On a misaligned access, go directly to DONE and set the error flag. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
- BUSY:
  - mem_req_o = 1.
  - On mem_ready_i, capture the extracted load data into the rdata register and go to DONE.
  - Timeout: the counter reaches TIMEOUT_CYCLES without mem_ready_i → rdata = 0, error flag set, go to DONE.
- DONE: core_stall_o = 0, lsu_err_o pulses if the error flag is set, then go to IDLE unconditionally.
- core_stall_o = core_req_i & (state ≠ DONE). This is combinational from core_req_i.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << addr[1:0].
  - W: 4'b1111.
  - Misaligned: 4'b0000, and no memory request is issued.
- Store data: B → {4{wd[7:0]}}; H → {2{wd[15:0]}}; W → wd.
- Load extract: shift mem_rd_i right by 8·addr[1:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Loads complete with rdata = 0 on misalignment or timeout; stores perform no write.
- core_size_i values 3, 6, 7 are treated as W.
- mem_ready_i outside BUSY is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - mem_req_o, mem_we_o = 0; mem_be_o = 0.
  - mem_addr_o, mem_wd_o, core_rd_o = 0.
  - lsu_err_o = 0; counter = 0.
- Cycle 0 (IDLE, core_req_i = 1): stall = 1. Cycle 1: BUSY, mem_req_o = 1.
- mem_ready_i in BUSY cycle n → DONE in cycle n+1. core_rd_o is valid and stall = 0 in that cycle.
- Minimum stall: 2 cycles (ready in the first BUSY cycle). Misaligned accesses: 1 cycle.
- mem_* outputs stay stable for the whole of BUSY and drop to 0 on leaving BUSY.
- Back-to-back accesses: a new core_req_i in the cycle after DONE starts a fresh access from IDLE.
- The counter clears on entering BUSY and saturates. With TIMEOUT_CYCLES = N, the abort occurs in BUSY cycle N; DONE follows.
- If mem_ready_i arrives in the same cycle as the timeout, ready wins and no error is flagged.
- Reset asserted mid-access returns the block to IDLE immediately, with all outputs at their reset values.
- core_rd_o holds its last value until the next load completes.

## Structure
- Shared riscv_pkg holds the size constants LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU.
- riscv_lsu_pkg holds the state enum lsu_state_t {IDLE, BUSY, DONE}.
- One sub-module, lsu_data_align: combinational be/wd generation and load extraction, reusable by a future cache.

## Test plan
- LW to 0x100, memory returns 0xDEADBEEF with ready in the first BUSY cycle:
  - mem_be_o = 1111.
  - Stall lasts 2 cycles.
  - core_rd_o = 0xDEADBEEF.
- LB to 0x103, mem_rd_i = 0x80FF_FF01 → mem_be_o = 1000, core_rd_o = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH of 0x1234ABCD to 0x202, ready after 3 cycles:
  - mem_be_o = 1100, mem_wd_o = 0xABCDABCD, mem_addr_o = 0x200.
  - Stall lasts 4 cycles.
- LW to 0x101 → no mem_req_o, 1-cycle stall, lsu_err_o pulse, core_rd_o = 0.
- TIMEOUT_CYCLES = 4, ready never asserted → abort after 4 BUSY cycles, lsu_err_o pulse, mem_req_o drops.
- rst_i driven low during BUSY → mem_req_o = 0 immediately. After release, a new LW completes normally.
